csi2_csr_regfile: RTL and testbench

CSI2_CSR_REGFILE -- requirements
Module: csi2_csr_regfile

---
 rtl/csi2_csr_pkg.sv | 19 +
 rtl/axi4_lite_if.sv | 33 +++
 rtl/csi2_csr_wr_join.sv | 68 ++++++
 rtl/csi2_csr_regfile.sv | 140 ++++++++++++++
 tb/tb_csi2_csr_regfile.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csi2_csr_pkg.sv
// csi2_csr_pkg: shared AXI response codes and register-map index constants
// for the CSI-2 CSR register file.
package csi2_csr_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axi_resp_e;

  // Control registers start at word index 0; status registers follow them.
  localparam int unsigned CR_BASE        = 0;
  localparam int unsigned CR_CNT_DEFAULT = 16;
  localparam int unsigned SR_CNT_DEFAULT = 16;

  function automatic int unsigned sr_base(input int unsigned cr_cnt);
    return CR_BASE + cr_cnt;
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// axi4_lite_if: AXI4-Lite register access bus with master/slave modports.
interface axi4_lite_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/csi2_csr_wr_join.sv
// csi2_csr_wr_join: one-entry holding registers for the AW and W channels,
// joined into a single write command. A beat arriving in the same cycle as
// its partner is bypassed straight to the command so no cycle is lost.
module csi2_csr_wr_join #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    aw_valid,
  input  logic [ADDR_WIDTH-1:0]   aw_addr,
  output logic                    aw_ready,
  input  logic                    w_valid,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic [DATA_WIDTH/8-1:0] w_strb,
  output logic                    w_ready,
  input  logic                    stall,
  output logic                    cmd_valid,
  output logic [ADDR_WIDTH-1:0]   cmd_addr,
  output logic [DATA_WIDTH-1:0]   cmd_data,
  output logic [DATA_WIDTH/8-1:0] cmd_strb
);

  logic                    aw_held;
  logic                    w_held;
  logic [ADDR_WIDTH-1:0]   aw_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [DATA_WIDTH/8-1:0] w_strb_q;
  logic                    aw_take;
  logic                    w_take;

  // Ready while the holding slot is empty; command from held or arriving beat.
  always_comb begin
    aw_ready  = !aw_held;
    w_ready   = !w_held;
    aw_take   = aw_valid && !aw_held;
    w_take    = w_valid && !w_held;
    cmd_addr  = aw_held ? aw_q : aw_addr;
    cmd_data  = w_held ? w_data_q : w_data;
    cmd_strb  = w_held ? w_strb_q : w_strb;
    cmd_valid = (aw_held || aw_take) && (w_held || w_take) && !stall;
  end

  // Holding registers: fill on handshake, free when the command commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_q     <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else if (cmd_valid) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_take) begin
        aw_held <= 1'b1;
        aw_q    <= aw_addr;
      end
      if (w_take) begin
        w_held   <= 1'b1;
        w_data_q <= w_data;
        w_strb_q <= w_strb;
      end
    end
  end

endmodule

// File: rtl/csi2_csr_regfile.sv
// csi2_csr_regfile: AXI4-Lite control/status register file.
// CRs at word index 0..CR_CNT-1, SRs at CR_CNT..CR_CNT+SR_CNT-1.
// Optional feature macro CSI2_CSR_SLVERR_EN: SLVERR responses for SR/unmapped
// writes and unmapped reads; without it every response is OKAY.
module csi2_csr_regfile
  import csi2_csr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CR_CNT     = CR_CNT_DEFAULT,
  parameter int unsigned SR_CNT     = SR_CNT_DEFAULT,
  parameter logic [CR_CNT-1:0] STB_MASK = '0,
  parameter logic [CR_CNT-1:0][DATA_WIDTH-1:0] CR_RST_VAL = '0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  axi4_lite_if.slave                        csr_if,
  output logic [CR_CNT-1:0][DATA_WIDTH-1:0] cr_o,
  output logic [CR_CNT-1:0]                 stb_o,
  input  logic [SR_CNT-1:0][DATA_WIDTH-1:0] sr_i
);

  localparam int unsigned BYTES   = DATA_WIDTH / 8;
  localparam int unsigned LSB     = $clog2(BYTES);
  localparam int unsigned SR_BASE = sr_base(CR_CNT);
  localparam int unsigned MAP_END = SR_BASE + SR_CNT;
`ifdef CSI2_CSR_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  logic                              cmd_valid;
  logic [ADDR_WIDTH-1:0]             cmd_addr;
  logic [DATA_WIDTH-1:0]             cmd_data;
  logic [BYTES-1:0]                  cmd_strb;
  logic [31:0]                       w_idx;
  logic [31:0]                       r_idx;
  logic [CR_CNT-1:0][DATA_WIDTH-1:0] cr_q;
  logic [CR_CNT-1:0]                 stb_q;
  logic                              bvalid_q;
  axi_resp_e                         bresp_q;
  axi_resp_e                         w_resp;
  logic                              rvalid_q;
  logic [DATA_WIDTH-1:0]             rdata_q;
  axi_resp_e                         rresp_q;
  logic [DATA_WIDTH-1:0]             rd_data;
  axi_resp_e                         rd_resp;

  csi2_csr_wr_join #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_join (
    .clk       (clk_i),
    .rst       (rst_i),
    .aw_valid  (csr_if.awvalid),
    .aw_addr   (csr_if.awaddr),
    .aw_ready  (csr_if.awready),
    .w_valid   (csr_if.wvalid),
    .w_data    (csr_if.wdata),
    .w_strb    (csr_if.wstrb),
    .w_ready   (csr_if.wready),
    .stall     (bvalid_q),
    .cmd_valid (cmd_valid),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_strb  (cmd_strb)
  );

  assign cr_o           = cr_q;
  assign stb_o          = stb_q;
  assign csr_if.bvalid  = bvalid_q;
  assign csr_if.bresp   = bresp_q;
  assign csr_if.arready = !rvalid_q;
  assign csr_if.rvalid  = rvalid_q;
  assign csr_if.rdata   = rdata_q;
  assign csr_if.rresp   = rresp_q;

  // Address decode, read mux and response selection.
  always_comb begin
    w_idx   = 32'(cmd_addr) >> LSB;
    r_idx   = 32'(csr_if.araddr) >> LSB;
    w_resp  = OKAY;
    rd_resp = OKAY;
    rd_data = '0;
    if (SLVERR_EN && w_idx >= SR_BASE) w_resp = SLVERR;
    if (SLVERR_EN && r_idx >= MAP_END) rd_resp = SLVERR;
    for (int unsigned i = 0; i < CR_CNT; i++) begin
      if (r_idx == CR_BASE + i) rd_data = cr_q[i];
    end
    for (int unsigned j = 0; j < SR_CNT; j++) begin
      if (r_idx == SR_BASE + j) rd_data = sr_i[j];
    end
  end

  // Write commit, strobe pulse generation and write response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cr_q     <= CR_RST_VAL;
      stb_q    <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
    end else begin
      stb_q <= '0;
      // A strobe bit lives for one cycle; a same-cycle write overrides the clear.
      for (int unsigned i = 0; i < CR_CNT; i++) begin
        if (stb_q[i]) cr_q[i][0] <= 1'b0;
      end
      if (bvalid_q && csr_if.bready) bvalid_q <= 1'b0;
      if (cmd_valid) begin
        bvalid_q <= 1'b1;
        bresp_q  <= w_resp;
        for (int unsigned i = 0; i < CR_CNT; i++) begin
          if (w_idx == CR_BASE + i) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
              if (cmd_strb[b]) cr_q[i][8*b +: 8] <= cmd_data[8*b +: 8];
            end
            if (STB_MASK[i] && cmd_strb[0] && cmd_data[0]) stb_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Read channel: capture data at the AR handshake, hold until rready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else if (rvalid_q) begin
      if (csr_if.rready) rvalid_q <= 1'b0;
    end else if (csr_if.arvalid) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= rd_resp;
    end
  end

endmodule

// File: tb/tb_csi2_csr_regfile.sv
// tb_csi2_csr_regfile: self-checking bench for csi2_csr_regfile with a
// word-indexed reference model of the register map.
`timescale 1ns/1ps
module tb_csi2_csr_regfile;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 8;
  localparam int unsigned NCR = 16;
  localparam int unsigned NSR = 16;
  localparam logic [NCR-1:0] STB = 16'h0004;

  function automatic logic [NCR-1:0][DW-1:0] mk_rst();
    logic [NCR-1:0][DW-1:0] r;
    r     = '0;
    r[5]  = 32'h1234_5678;
    r[7]  = 32'hDEAD_BEEF;
    r[9]  = 32'h0BAD_F00D;
    r[10] = 32'h0000_00FF;
    return r;
  endfunction
  localparam logic [NCR-1:0][DW-1:0] RST_VALS = mk_rst();

`ifdef CSI2_CSR_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NCR-1:0][DW-1:0] cr;
  logic [NCR-1:0]         stb;
  logic [NSR-1:0][DW-1:0] sr;
  int total = 0;
  int bad   = 0;
  logic [DW-1:0] m_cr [NCR];

  axi4_lite_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  csi2_csr_regfile #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CR_CNT     (NCR),
    .SR_CNT     (NSR),
    .STB_MASK   (STB),
    .CR_RST_VAL (RST_VALS)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .csr_if (bus),
    .cr_o   (cr),
    .stb_o  (stb),
    .sr_i   (sr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] exp_read(input int unsigned idx);
    if (idx < NCR) return m_cr[idx];
    if (idx < NCR + NSR) return sr[idx-NCR];
    return '0;
  endfunction

  function automatic logic [1:0] exp_bresp(input int unsigned idx);
    return (idx < NCR) ? 2'b00 : ERR;
  endfunction

  function automatic logic [1:0] exp_rresp(input int unsigned idx);
    return (idx < NCR + NSR) ? 2'b00 : ERR;
  endfunction

  function automatic void model_write(input int unsigned idx, input logic [DW-1:0] d,
                                      input logic [3:0] s);
    logic [DW-1:0] v;
    if (idx >= NCR) return;
    v = m_cr[idx];
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    if (STB[idx] && s[0] && d[0]) v[0] = 1'b0;
    m_cr[idx] = v;
  endfunction

  function automatic logic [NCR-1:0][DW-1:0] model_pack();
    logic [NCR-1:0][DW-1:0] p;
    for (int i = 0; i < NCR; i++) p[i] = m_cr[i];
    return p;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NCR; i++) m_cr[i] = RST_VALS[i];
  endfunction

  // ---------------- bus helpers (entered and left at a negedge) ----------------
  task automatic axi_write(input int unsigned idx, input logic [DW-1:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit fa, fw, fb, done;
    done = 0;
    resp = 2'bxx;
    bus.awaddr  = AW'(idx * 4 + $urandom_range(0, 3));
    bus.awvalid = 1'b1;
    bus.wdata   = d;
    bus.wstrb   = s;
    bus.wvalid  = 1'b1;
    bus.bready  = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      fa = bus.awvalid && bus.awready;
      fw = bus.wvalid && bus.wready;
      fb = bus.bvalid && bus.bready;
      if (fb) resp = bus.bresp;
      @(negedge clk);
      if (fa) bus.awvalid = 1'b0;
      if (fw) bus.wvalid = 1'b0;
      if (fb) done = 1;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL wr_timeout idx=%0d got=no_response exp=bvalid", idx);
    end
    model_write(idx, d, s);
  endtask

  task automatic axi_read(input int unsigned idx, output logic [DW-1:0] d, output logic [1:0] resp);
    bit fa, fr, done;
    done = 0;
    d    = 'x;
    resp = 2'bxx;
    bus.araddr  = AW'(idx * 4 + $urandom_range(0, 3));
    bus.arvalid = 1'b1;
    bus.rready  = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      fa = bus.arvalid && bus.arready;
      fr = bus.rvalid && bus.rready;
      if (fr) begin
        d    = bus.rdata;
        resp = bus.rresp;
      end
      @(negedge clk);
      if (fa) bus.arvalid = 1'b0;
      if (fr) done = 1;
    end
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL rd_timeout idx=%0d got=no_response exp=rvalid", idx);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    total++; if (cr !== RST_VALS) begin bad++; $display("FAIL rst_cr got=%h exp=%h", cr, RST_VALS); end
    total++; if (stb !== '0) begin bad++; $display("FAIL rst_stb got=%h exp=0", stb); end
    total++; if (bus.bvalid !== 1'b0) begin bad++; $display("FAIL rst_bvalid got=%b exp=0", bus.bvalid); end
    total++; if (bus.rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b exp=0", bus.rvalid); end
    total++; if (bus.rdata !== '0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", bus.rdata); end
    total++; if (bus.bresp !== 2'b00 || bus.rresp !== 2'b00) begin
      bad++; $display("FAIL rst_resp got=%b/%b exp=00/00", bus.bresp, bus.rresp);
    end
    total++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
      bad++; $display("FAIL rst_ready got=%b exp=111", {bus.awready, bus.wready, bus.arready});
    end
  endtask

  task automatic test_timing();
    logic [DW-1:0] d;
    d = $urandom;
    bus.bready  = 1'b1;
    bus.awaddr  = AW'(3 * 4);
    bus.awvalid = 1'b1;
    @(negedge clk);  // cycle 1
    bus.awvalid = 1'b0;
    total++; if (bus.awready !== 1'b0) begin bad++; $display("FAIL t_aw_held got=%b exp=0", bus.awready); end
    @(negedge clk);  // cycle 2
    total++; if (bus.bvalid !== 1'b0) begin bad++; $display("FAIL t_early_b2 got=%b exp=0", bus.bvalid); end
    @(negedge clk);  // cycle 3
    total++; if (bus.bvalid !== 1'b0 || bus.wready !== 1'b1) begin
      bad++; $display("FAIL t_c3 got=b%b/w%b exp=b0/w1", bus.bvalid, bus.wready);
    end
    bus.wdata  = d;
    bus.wstrb  = 4'hF;
    bus.wvalid = 1'b1;
    @(negedge clk);  // cycle 4
    bus.wvalid = 1'b0;
    model_write(3, d, 4'hF);
    total++; if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin
      bad++; $display("FAIL t_bvalid_c4 got=%b/%b exp=1/00", bus.bvalid, bus.bresp);
    end
    total++; if (cr[3] !== m_cr[3]) begin bad++; $display("FAIL t_cr3 got=%h exp=%h", cr[3], m_cr[3]); end
    @(negedge clk);  // cycle 5
    total++; if (bus.bvalid !== 1'b0) begin bad++; $display("FAIL t_bclear got=%b exp=0", bus.bvalid); end
    bus.bready = 1'b0;
  endtask

  task automatic test_byte_strobe();
    logic [1:0] r;
    total++; if (cr[1] !== 32'h0) begin bad++; $display("FAIL bs_pre got=%h exp=0", cr[1]); end
    axi_write(1, 32'hA5A5_A5A5, 4'b0101, r);
    total++; if (cr[1] !== 32'h00A5_00A5) begin bad++; $display("FAIL bs_cr1 got=%h exp=00a500a5", cr[1]); end
    total++; if (r !== 2'b00) begin bad++; $display("FAIL bs_resp got=%b exp=00", r); end
  endtask

  task automatic test_strobe_reg();
    bus.bready  = 1'b1;
    bus.awaddr  = AW'(2 * 4);
    bus.wdata   = 32'h0000_0001;
    bus.wstrb   = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    total++; if (stb !== 16'h0004 || cr[2][0] !== 1'b1) begin
      bad++; $display("FAIL stb_pulse got=stb%h/b0%b exp=stb0004/b01", stb, cr[2][0]);
    end
    @(negedge clk);
    total++; if (stb !== '0 || cr[2][0] !== 1'b0) begin
      bad++; $display("FAIL stb_clear got=stb%h/b0%b exp=stb0000/b00", stb, cr[2][0]);
    end
    model_write(2, 32'h1, 4'hF);
    // same write to a non-strobe register: no pulse, bit stays set
    bus.awaddr  = AW'(4 * 4);
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      total++; if (stb !== '0) begin bad++; $display("FAIL stb_nonstrobe got=%h exp=0", stb); end
    end
    model_write(4, 32'h1, 4'hF);
    total++; if (cr[4] !== m_cr[4]) begin bad++; $display("FAIL stb_cr4 got=%h exp=%h", cr[4], m_cr[4]); end
    bus.bready = 1'b0;
  endtask

  task automatic test_read_hold();
    logic [DW-1:0] samp;
    samp        = $urandom;
    sr[0]       = samp;
    bus.rready  = 1'b0;
    bus.araddr  = AW'(NCR * 4);
    bus.arvalid = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sr[0] = $urandom;
      total++; if (bus.rvalid !== 1'b1 || bus.rdata !== samp || bus.arready !== 1'b0 || bus.rresp !== 2'b00) begin
        bad++; $display("FAIL rd_hold got=v%b/%h/ar%b exp=v1/%h/ar0", bus.rvalid, bus.rdata, bus.arready, samp);
      end
      @(negedge clk);
    end
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    total++; if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
      bad++; $display("FAIL rd_release got=v%b/ar%b exp=v0/ar1", bus.rvalid, bus.arready);
    end
  endtask

  task automatic test_unmapped();
    logic [DW-1:0] d;
    logic [1:0] r;
    axi_read(NCR + NSR, d, r);
    total++; if (d !== '0 || r !== ERR) begin bad++; $display("FAIL um_rd32 got=%h/%b exp=0/%b", d, r, ERR); end
    axi_read(63, d, r);
    total++; if (d !== '0 || r !== ERR) begin bad++; $display("FAIL um_rd63 got=%h/%b exp=0/%b", d, r, ERR); end
    axi_write(NCR + 4, $urandom, 4'hF, r);
    total++; if (r !== ERR) begin bad++; $display("FAIL um_wr_sr got=%b exp=%b", r, ERR); end
    axi_write(45, $urandom, 4'hF, r);
    total++; if (r !== ERR) begin bad++; $display("FAIL um_wr45 got=%b exp=%b", r, ERR); end
    total++; if (cr !== model_pack()) begin bad++; $display("FAIL um_nochange got=%h exp=%h", cr, model_pack()); end
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] old_v, new_v;
    old_v = m_cr[6];
    new_v = $urandom;
    bus.awaddr = AW'(6 * 4);
    bus.araddr = AW'(6 * 4);
    bus.wdata  = new_v;
    bus.wstrb  = 4'hF;
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    bus.arvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.arvalid = 1'b0;
    model_write(6, new_v, 4'hF);
    total++; if (bus.rvalid !== 1'b1 || bus.rdata !== old_v) begin
      bad++; $display("FAIL sc_rd got=%b/%h exp=1/%h", bus.rvalid, bus.rdata, old_v);
    end
    total++; if (bus.bvalid !== 1'b1 || cr[6] !== new_v) begin
      bad++; $display("FAIL sc_wr got=%b/%h exp=1/%h", bus.bvalid, cr[6], new_v);
    end
    @(negedge clk);
    bus.bready = 1'b0;
    bus.rready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exq[$];
    int unsigned idx;
    int nread;
    bit fa, fr;
    logic [DW-1:0] e;
    for (int j = 0; j < NSR; j++) sr[j] = $urandom;
    idx = 10;
    nread = 0;
    bus.araddr  = AW'(idx * 4);
    bus.arvalid = 1'b1;
    bus.rready  = 1'b1;
    for (int c = 0; c < 12; c++) begin
      fa = bus.arvalid && bus.arready;
      fr = bus.rvalid && bus.rready;
      if (fr) begin
        e = (exq.size() > 0) ? exq.pop_front() : 'x;
        nread++;
        total++; if (bus.rdata !== e) begin bad++; $display("FAIL b2b_data got=%h exp=%h", bus.rdata, e); end
      end
      if (fa) exq.push_back(exp_read(idx));
      @(negedge clk);
      if (fa) begin
        idx++;
        bus.araddr = AW'(idx * 4);
      end
    end
    bus.arvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (bus.rvalid && bus.rready) begin
        e = (exq.size() > 0) ? exq.pop_front() : 'x;
        nread++;
        total++; if (bus.rdata !== e) begin bad++; $display("FAIL b2b_drain got=%h exp=%h", bus.rdata, e); end
      end
      @(negedge clk);
    end
    bus.rready = 1'b0;
    total++; if (nread < 6 || exq.size() != 0) begin
      bad++; $display("FAIL b2b_rate got=%0d reads/%0d left exp=>=6/0", nread, exq.size());
    end
  endtask

  task automatic test_random();
    int unsigned idx;
    logic [DW-1:0] d, e;
    logic [3:0] s;
    logic [1:0] r, er;
    for (int k = 0; k < 80; k++) begin
      idx = $urandom_range(0, 40);
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        er = exp_bresp(idx);
        axi_write(idx, d, s, r);
        total++; if (r !== er) begin bad++; $display("FAIL rnd_bresp idx=%0d got=%b exp=%b", idx, r, er); end
        total++; if (cr !== model_pack()) begin bad++; $display("FAIL rnd_cr idx=%0d got=%h exp=%h", idx, cr, model_pack()); end
      end else begin
        for (int j = 0; j < NSR; j++) sr[j] = $urandom;
        e  = exp_read(idx);
        er = exp_rresp(idx);
        axi_read(idx, d, r);
        total++; if (d !== e || r !== er) begin
          bad++; $display("FAIL rnd_rd idx=%0d got=%h/%b exp=%h/%b", idx, d, r, e, er);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.bready  = 1'b1;
    bus.awaddr  = AW'(9 * 4);
    bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    total++; if (bus.awready !== 1'b0 || bus.bvalid !== 1'b0) begin
      bad++; $display("FAIL rm_held got=ar%b/b%b exp=ar0/b0", bus.awready, bus.bvalid);
    end
    bus.wdata  = 32'hFFFF_FFFF;
    bus.wstrb  = 4'hF;
    bus.wvalid = 1'b1;
    rst        = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    bus.wvalid = 1'b0;
    model_reset();
    total++; if (cr[9] !== RST_VALS[9] || bus.bvalid !== 1'b0) begin
      bad++; $display("FAIL rm_nocommit got=%h/b%b exp=%h/b0", cr[9], bus.bvalid, RST_VALS[9]);
    end
    total++; if (bus.awready !== 1'b1 || bus.wready !== 1'b1) begin
      bad++; $display("FAIL rm_ready got=%b%b exp=11", bus.awready, bus.wready);
    end
    repeat (3) @(negedge clk);
    total++; if (bus.bvalid !== 1'b0 || cr !== model_pack()) begin
      bad++; $display("FAIL rm_after got=b%b/%h exp=b0/%h", bus.bvalid, cr, model_pack());
    end
    bus.bready = 1'b0;
  endtask

  initial begin
    bus.awaddr  = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    bus.araddr  = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    sr          = '0;
    @(negedge clk);
    test_reset();
    test_timing();
    test_byte_strobe();
    test_strobe_reg();
    test_read_hold();
    test_unmapped();
    test_same_cycle();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
